ex_mem_issue_reg: RTL
=====================

# ex_mem_issue_reg

Parametrised EX→MEM pipeline boundary for an N-issue core: registers per-lane execute results into the memory stage and arbitrates per-lane branch redirects and exception/CSR/ERTN flush requests by program order (lane 0 oldest). It generalises the dual-issue EX/MEM register from 2 lanes to ISSUE_WIDTH lanes.
- Any lane can redirect; all younger lanes are killed.
- A registered BPU update record is produced one cycle after the redirect.
- Saturating statistics counters track redirects, killed lanes and inserted bubbles.

## Interface
- ISSUE_WIDTH, 2, number of issue lanes (1..8); lane 0 is oldest.
- DATA_W, 128, width of one lane's opaque ex_mem payload.
- CNT_W, 32, width of each statistics counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- flush  in  1  global flush from ctrl.
- pause  in  1  global stall from ctrl; holds the register.
- pause_ex  in  1  EX stage is stalled (multi-cycle ALU, dcache not addr_ok).
- pause_mem  in  1  MEM stage is stalled.
- ex_valid  in  ISSUE_WIDTH  lane carries a live instruction.
- ex_payload  in  ISSUE_WIDTH×DATA_W  lane result packet.
- ex_redirect  in  ISSUE_WIDTH  lane's branch resolved mispredicted.
- ex_target  in  ISSUE_WIDTH×32  lane's redirect target PC.
- ex_excp  in  ISSUE_WIDTH  lane raises exception, CSR write or ERTN.
- mem_valid  out  ISSUE_WIDTH  registered lane valid into MEM.
- mem_payload  out  ISSUE_WIDTH×DATA_W  registered lane payload into MEM.
- branch_flush  out  1  redirect request to ctrl (combinational).
- branch_target  out  32  target of the winning redirect lane.
- ex_excp_flush  out  1  exception-class flush request to ctrl (combinational).
- upd_valid  out  1  registered BPU update strobe.
- upd_lane  out  $clog2(ISSUE_WIDTH) (min 1)  lane that redirected.
- upd_target  out  32  registered redirect target.
- cnt_redirect, cnt_killed, cnt_bubble  out  CNT_W each  statistics.

## Operation
- Effective lane flags: r_i = ex_valid[i] & ex_redirect[i]; e_i = ex_valid[i] & ex_excp[i].
- Stop lane k = lowest i with r_i | e_i. Lanes j > k are killed. Lane k itself passes through.
- Winner: if a stop lane exists and r_k = 1, it is the redirect winner. A redirect in a lane younger than k is ignored.
- go = !pause_ex & !pause_mem.
- branch_flush = go & r_k.
- branch_target = ex_target[k] when r_k = 1, else 0.
- ex_excp_flush = go & e_k. If r_k and e_k are both set, both flush outputs assert.
- Register update, priority order:
  - (1) rst low → clear.
  - (2) flush → clear.
  - (3) bubble = pause_ex & !pause_mem → clear.
  - (4) !pause → load. mem_valid[i] = ex_valid[i] & !killed_i. Killed or invalid lanes load payload 0.
  - (5) else hold.
- Clear means all mem_valid = 0 and all mem_payload = 0.
- BPU record: on a clock edge where branch_flush = 1, set upd_valid = 1 and load upd_lane = k and upd_target = ex_target[k]. Otherwise upd_valid = 0; upd_lane and upd_target hold their values. flush does not suppress a same-cycle record.
- Counters:
  - cnt_redirect += 1 when branch_flush = 1.
  - cnt_bubble += 1 when the bubble condition is selected (not masked by flush).
  - cnt_killed += popcount(ex_valid & killed) on a load cycle.
  - All counters saturate at 2^CNT_W−1 and are cleared only by reset.

## Timing
- Reset values: mem_valid = 0, mem_payload = 0, upd_valid = 0, upd_lane = 0, upd_target = 0, all counters = 0.
- Reset is asynchronous. Deasserting mid-operation resumes loading on the first edge with rst high.
- EX→MEM latency: 1 cycle.
- branch_flush, branch_target and ex_excp_flush are same-cycle combinational outputs; no input-to-output register.
- upd_* lag branch_flush by exactly 1 cycle; upd_valid is a single-cycle pulse per redirect edge.
- pause and pause_mem together: hold, not bubble.
- pause_ex alone: one bubble per cycle for as long as it is high.
- A redirect is reported only while go = 1. A redirect stalled by pause_ex is re-evaluated each cycle until go.
- Saturation boundary: a counter at max stays at max; there is no wrap.
- ISSUE_WIDTH = 1: kill logic is trivially empty; upd_lane is always 0.

## Test plan
- Reset: hold rst = 0 with random inputs → all outputs 0. Release, ISSUE_WIDTH = 2, ex_valid = 2'b11, payloads 0xA/0xB, no pauses → next cycle mem_valid = 11, payloads A/B.
- Kill younger, ISSUE_WIDTH = 4: ex_valid = 4'hF, ex_redirect = 4'b0010, ex_target[1] = 0x1C000100 → branch_flush = 1, branch_target = 0x1C000100. Next cycle: mem_valid = 4'b0011; lanes 2–3 payload 0; upd_valid = 1, upd_lane = 1, upd_target = 0x1C000100; cnt_killed = 2, cnt_redirect = 1.
- Older exception masks younger redirect: ex_excp = 4'b0001, ex_redirect = 4'b0100 → ex_excp_flush = 1, branch_flush = 0, mem_valid = 4'b0001, upd_valid = 0 next cycle.
- Pause interplay:
  - pause_ex = 1, pause_mem = 0 for 3 cycles with a redirect present → branch_flush = 0 throughout, mem_valid = 0 each cycle, cnt_bubble = 3.
  - Then pause_ex = 0 → branch_flush = 1 that cycle.
  - pause = pause_mem = 1 → mem_* unchanged.
- flush with load data and redirect on the same edge → mem_valid = 0 and upd_valid = 1 next cycle.
- Saturation: CNT_W = 2, drive 5 redirects → cnt_redirect = 3.

Source files
------------

// File: rtl/ex_mem_issue_reg.sv
// EX->MEM pipeline register for an N-issue core: per-lane result staging,
// program-order redirect/exception arbitration, BPU update record and statistics.
module ex_mem_issue_reg #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned CNT_W       = 32,
    localparam int unsigned LANE_W     = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          pause,
    input  logic                          pause_ex,
    input  logic                          pause_mem,
    input  logic [ISSUE_WIDTH-1:0]        ex_valid,
    input  logic [ISSUE_WIDTH*DATA_W-1:0] ex_payload,
    input  logic [ISSUE_WIDTH-1:0]        ex_redirect,
    input  logic [ISSUE_WIDTH*32-1:0]     ex_target,
    input  logic [ISSUE_WIDTH-1:0]        ex_excp,
    output logic [ISSUE_WIDTH-1:0]        mem_valid,
    output logic [ISSUE_WIDTH*DATA_W-1:0] mem_payload,
    output logic                          branch_flush,
    output logic [31:0]                   branch_target,
    output logic                          ex_excp_flush,
    output logic                          upd_valid,
    output logic [LANE_W-1:0]             upd_lane,
    output logic [31:0]                   upd_target,
    output logic [CNT_W-1:0]              cnt_redirect,
    output logic [CNT_W-1:0]              cnt_killed,
    output logic [CNT_W-1:0]              cnt_bubble
);

    localparam int unsigned KCNT_W = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned SUM_W  = CNT_W + KCNT_W;

    logic [ISSUE_WIDTH-1:0]        r_lane;
    logic [ISSUE_WIDTH-1:0]        e_lane;
    logic [ISSUE_WIDTH-1:0]        killed;
    logic [ISSUE_WIDTH-1:0]        live;
    logic                          found;
    logic                          stop_r;
    logic                          stop_e;
    logic [LANE_W-1:0]             stop_idx;
    logic [31:0]                   stop_target;
    logic [KCNT_W-1:0]             kill_cnt;
    logic [ISSUE_WIDTH*DATA_W-1:0] load_payload;
    logic                          go;
    logic                          bubble;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0]  cnt,
                                                 input logic [KCNT_W-1:0] amt);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(amt);
        if (sum > SUM_W'({CNT_W{1'b1}}))
            return '1;
        return sum[CNT_W-1:0];
    endfunction

    assign r_lane = ex_valid & ex_redirect;
    assign e_lane = ex_valid & ex_excp;

    // Oldest lane with a redirect or exception stops the group; everything younger is killed.
    always_comb begin
        found       = 1'b0;
        killed      = '0;
        stop_r      = 1'b0;
        stop_e      = 1'b0;
        stop_idx    = '0;
        stop_target = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (found) begin
                killed[i] = 1'b1;
            end else if (r_lane[i] | e_lane[i]) begin
                found       = 1'b1;
                stop_idx    = LANE_W'(i);
                stop_r      = r_lane[i];
                stop_e      = e_lane[i];
                stop_target = ex_target[i*32 +: 32];
            end
        end
    end

    assign live = ex_valid & ~killed;

    always_comb begin
        kill_cnt     = '0;
        load_payload = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            kill_cnt = kill_cnt + KCNT_W'(ex_valid[i] & killed[i]);
            if (live[i])
                load_payload[i*DATA_W +: DATA_W] = ex_payload[i*DATA_W +: DATA_W];
        end
    end

    assign go            = ~pause_ex & ~pause_mem;
    assign bubble        = pause_ex & ~pause_mem;
    assign branch_flush  = go & stop_r;
    assign branch_target = stop_r ? stop_target : '0;
    assign ex_excp_flush = go & stop_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid   <= '0;
            mem_payload <= '0;
        end else if (flush || bubble) begin
            mem_valid   <= '0;
            mem_payload <= '0;
        end else if (!pause) begin
            mem_valid   <= live;
            mem_payload <= load_payload;
        end
    end

    // The update record is independent of flush so a redirect is never lost to the predictor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid  <= 1'b0;
            upd_lane   <= '0;
            upd_target <= '0;
        end else if (branch_flush) begin
            upd_valid  <= 1'b1;
            upd_lane   <= stop_idx;
            upd_target <= stop_target;
        end else begin
            upd_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_redirect <= '0;
            cnt_killed   <= '0;
            cnt_bubble   <= '0;
        end else begin
            if (branch_flush)
                cnt_redirect <= sat_add(cnt_redirect, KCNT_W'(1));
            if (!flush && bubble)
                cnt_bubble <= sat_add(cnt_bubble, KCNT_W'(1));
            if (!flush && !bubble && !pause)
                cnt_killed <= sat_add(cnt_killed, kill_cnt);
        end
    end

endmodule
